// File: rtl/mvm_result_serializer.sv
// Breaks wide AXI-S result beats into OUTW-bit words, LSB word first, with zero-bubble beat chaining.
// Optional: define MVM_RESULT_SERIALIZER_COUNT_EN to add the FRAME_COUNT output (count of TLAST words sent).
module mvm_result_serializer #(
    parameter int DATAW = 512,
    parameter int OUTW  = 32,
    parameter int USERW = 1,
    parameter int DESTW = 9
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             AXIS_S_TVALID,
    output logic             AXIS_S_TREADY,
    input  logic [DATAW-1:0] AXIS_S_TDATA,
    input  logic             AXIS_S_TLAST,
    input  logic [USERW-1:0] AXIS_S_TUSER,
    input  logic [DESTW-1:0] AXIS_S_TDEST,
    output logic             AXIS_M_TVALID,
    input  logic             AXIS_M_TREADY,
    output logic [OUTW-1:0]  AXIS_M_TDATA,
    output logic             AXIS_M_TLAST,
    output logic [USERW-1:0] AXIS_M_TUSER,
    output logic [DESTW-1:0] AXIS_M_TDEST
`ifdef MVM_RESULT_SERIALIZER_COUNT_EN
    ,
    output logic [15:0]      FRAME_COUNT
`endif
);

    localparam int RATIO = DATAW / OUTW;
    localparam int IDXW  = (RATIO > 1) ? $clog2(RATIO) : 1;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                       state, state_nxt;
    logic [IDXW-1:0]              idx, idx_nxt;
    logic [RATIO-1:0][OUTW-1:0]   beat;
    logic                         last_q;
    logic [USERW-1:0]             user_q;
    logic [DESTW-1:0]             dest_q;
    logic                         idx_last;
    logic                         s_ready;
    logic                         load;

    assign idx_last = (idx == IDXW'(RATIO - 1));

    // Ready is gated by reset so the port reads 0 while RST_N is low even though state sits at IDLE.
    assign s_ready = RST_N & ((state == IDLE) | ((state == SHIFT) & idx_last & AXIS_M_TREADY));
    assign load    = AXIS_S_TVALID & s_ready;

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        case (state)
            IDLE: begin
                if (AXIS_S_TVALID) begin
                    state_nxt = SHIFT;
                    idx_nxt   = '0;
                end
            end
            SHIFT: begin
                if (AXIS_M_TREADY) begin
                    if (idx_last) begin
                        idx_nxt = '0;
                        if (!AXIS_S_TVALID) begin
                            state_nxt = IDLE;
                        end
                    end else begin
                        idx_nxt = idx + IDXW'(1);
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                idx_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state  <= IDLE;
            idx    <= '0;
            beat   <= '0;
            last_q <= 1'b0;
            user_q <= '0;
            dest_q <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            if (load) begin
                beat   <= AXIS_S_TDATA;
                last_q <= AXIS_S_TLAST;
                user_q <= AXIS_S_TUSER;
                dest_q <= AXIS_S_TDEST;
            end
        end
    end

    assign AXIS_S_TREADY = s_ready;
    assign AXIS_M_TVALID = (state == SHIFT);
    assign AXIS_M_TDATA  = beat[idx];
    assign AXIS_M_TLAST  = last_q & idx_last & (state == SHIFT);
    assign AXIS_M_TUSER  = user_q;
    assign AXIS_M_TDEST  = dest_q;

`ifdef MVM_RESULT_SERIALIZER_COUNT_EN
    logic [15:0] frame_cnt;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            frame_cnt <= 16'd0;
        end else if (AXIS_M_TVALID & AXIS_M_TREADY & AXIS_M_TLAST) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end

    assign FRAME_COUNT = frame_cnt;
`else
`endif

endmodule
